// File: rtl/comm_receiver_fifo.sv
// Pong-link serial receiver: deserialises UART-style frames into a message FIFO.
// Define COMM_RX_PARITY_EN for frames carrying an even-parity bit before the stop bit.
module comm_receiver_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int Y_W          = 9,
    parameter int V_W          = 4,
    parameter int DEPTH        = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           rx_serial,
    output logic           new_message_received,
    input  logic           message_acked,
    output logic [Y_W-1:0] ball_y_rx,
    output logic [V_W-1:0] velocity_x_rx,
    output logic [V_W-1:0] velocity_y_rx,
    output logic           sign_y_rx,
    output logic           ball_message_rx,
    output logic           miss_message_rx,
    output logic           are_you_there_rx,
    output logic           I_am_here_rx,
    output logic           I_lost_rx,
    output logic           new_game_message_rx,
    output logic           rx_busy,
    output logic [7:0]     frame_err_count,
    output logic [7:0]     overflow_count
);

    localparam int MSG_W = 4 + Y_W + 2 * V_W;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(MSG_W);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    logic sync_q1;
    logic sync_q2;
    logic rx_prev;
    logic fall;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_q1 <= rx_serial;
            sync_q2 <= sync_q1;
            rx_prev <= sync_q2;
        end
    end

    assign fall = rx_prev & ~sync_q2;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [MSG_W-1:0] shreg_q, shreg_d;
    logic             stop_sample;
`ifdef COMM_RX_PARITY_EN
    logic             par_q, par_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
`ifdef COMM_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
`ifdef COMM_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        stop_sample = 1'b0;
`ifdef COMM_RX_PARITY_EN
        par_d       = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A line back high at mid-bit was noise, not a start bit
                    state_d = sync_q2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shreg_d = {sync_q2, shreg_q[MSG_W-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
`ifdef COMM_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef COMM_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    par_d   = sync_q2;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d       = '0;
                    stop_sample = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    logic bad_type;
    logic par_err;
    logic frame_bad;
    logic frame_good;

    assign bad_type = shreg_q[2:0] > 3'd5;
`ifdef COMM_RX_PARITY_EN
    assign par_err  = par_q != (^shreg_q);
`else
    assign par_err  = 1'b0;
`endif
    assign frame_bad  = stop_sample & (~sync_q2 | par_err | bad_type);
    assign frame_good = stop_sample & sync_q2 & ~par_err & ~bad_type;

    logic [MSG_W-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_q;
    logic [PTR_W:0]   rd_q;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             overflow;

    assign empty = wr_q == rd_q;
    assign full  = (wr_q ^ rd_q) == {1'b1, {PTR_W{1'b0}}};
    assign pop   = message_acked & ~empty;
    // A pop in the same cycle frees the slot the push lands in
    assign push     = frame_good & (~full | pop);
    assign overflow = frame_good & full & ~pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_q[PTR_W-1:0]] <= shreg_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_err_count <= '0;
            overflow_count  <= '0;
        end else begin
            if (frame_bad && frame_err_count != 8'hFF) begin
                frame_err_count <= frame_err_count + 1'b1;
            end
            if (overflow && overflow_count != 8'hFF) begin
                overflow_count <= overflow_count + 1'b1;
            end
        end
    end

    logic [MSG_W-1:0] head;
    logic [2:0]       head_type;

    assign head      = empty ? '0 : mem[rd_q[PTR_W-1:0]];
    assign head_type = head[2:0];

    assign new_message_received = ~empty;
    assign sign_y_rx            = head[3];
    assign ball_y_rx            = head[4 +: Y_W];
    assign velocity_x_rx        = head[4 + Y_W +: V_W];
    assign velocity_y_rx        = head[4 + Y_W + V_W +: V_W];

    assign ball_message_rx     = ~empty & (head_type == 3'd0);
    assign miss_message_rx     = ~empty & (head_type == 3'd1);
    assign are_you_there_rx    = ~empty & (head_type == 3'd2);
    assign I_am_here_rx        = ~empty & (head_type == 3'd3);
    assign I_lost_rx           = ~empty & (head_type == 3'd4);
    assign new_game_message_rx = ~empty & (head_type == 3'd5);

    assign rx_busy = state_q != S_IDLE;

endmodule

// File: tb/tb_comm_receiver_fifo.sv
// Scoreboard bench for comm_receiver_fifo: random and directed frames against
// a queue-based model; a monitor process acknowledges and checks head messages.
module tb_comm_receiver_fifo;

    localparam int CPB   = 8;
    localparam int Y_W   = 9;
    localparam int V_W   = 4;
    localparam int DEPTH = 4;
    localparam int MSG_W = 4 + Y_W + 2 * V_W;
`ifdef COMM_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic           clock;
    logic           reset;
    logic           rx_serial;
    logic           message_acked;
    logic           new_message_received;
    logic [Y_W-1:0] ball_y_rx;
    logic [V_W-1:0] velocity_x_rx;
    logic [V_W-1:0] velocity_y_rx;
    logic           sign_y_rx;
    logic           ball_message_rx;
    logic           miss_message_rx;
    logic           are_you_there_rx;
    logic           I_am_here_rx;
    logic           I_lost_rx;
    logic           new_game_message_rx;
    logic           rx_busy;
    logic [7:0]     frame_err_count;
    logic [7:0]     overflow_count;
    logic [5:0]     flags;

    comm_receiver_fifo #(
        .CLKS_PER_BIT(CPB),
        .Y_W(Y_W),
        .V_W(V_W),
        .DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx_serial(rx_serial),
        .new_message_received(new_message_received),
        .message_acked(message_acked),
        .ball_y_rx(ball_y_rx),
        .velocity_x_rx(velocity_x_rx),
        .velocity_y_rx(velocity_y_rx),
        .sign_y_rx(sign_y_rx),
        .ball_message_rx(ball_message_rx),
        .miss_message_rx(miss_message_rx),
        .are_you_there_rx(are_you_there_rx),
        .I_am_here_rx(I_am_here_rx),
        .I_lost_rx(I_lost_rx),
        .new_game_message_rx(new_game_message_rx),
        .rx_busy(rx_busy),
        .frame_err_count(frame_err_count),
        .overflow_count(overflow_count)
    );

    assign flags = {new_game_message_rx, I_lost_rx, I_am_here_rx,
                    are_you_there_rx, miss_message_rx, ball_message_rx};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [MSG_W-1:0] exp_q[$];
    int rd_idx    = 0;
    int flush_to  = 0;
    int exp_err   = 0;
    int exp_ovf   = 0;
    bit auto_ack  = 1'b0;
    int stray_req = 0;
    int stray_done = 0;

    task automatic expect_eq(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [MSG_W-1:0] mk(input logic [2:0] t, input logic s,
                                            input logic [Y_W-1:0] y,
                                            input logic [V_W-1:0] vx,
                                            input logic [V_W-1:0] vy);
        return {vy, vx, y, s, t};
    endfunction

    function automatic logic [MSG_W-1:0] rnd(input logic [2:0] t);
        return mk(t, 1'($urandom), Y_W'($urandom), V_W'($urandom), V_W'($urandom));
    endfunction

    task automatic check_head(input logic [MSG_W-1:0] p);
        logic [5:0] ef;
        ef = 6'b1 << p[2:0];
        expect_eq("head_fields",
                  32'({ball_y_rx, velocity_x_rx, velocity_y_rx, sign_y_rx}),
                  32'({p[4 +: Y_W], p[4 + Y_W +: V_W], p[4 + Y_W + V_W +: V_W], p[3]}));
        expect_eq("head_type_flags", 32'(flags), 32'(ef));
    endtask

    // Monitor: pops the scoreboard each time it acknowledges a presented message
    initial begin
        message_acked = 1'b0;
        forever begin
            @(negedge clock);
            if (rd_idx < flush_to) rd_idx = flush_to;
            if (message_acked) begin
                message_acked = 1'b0;
            end else if ((auto_ack && new_message_received) || stray_done != stray_req) begin
                if (stray_done != stray_req) stray_done++;
                if (new_message_received) begin
                    expect_eq("msg_expected", 32'(rd_idx < exp_q.size()), 32'd1);
                    if (rd_idx < exp_q.size()) begin
                        check_head(exp_q[rd_idx]);
                        rd_idx++;
                    end
                end
                message_acked = 1'b1;
            end
        end
    end

    task automatic model_frame(input logic [MSG_W-1:0] p, input logic stop_v,
                               input logic par_flip, input bit pop_same);
        int occ;
        occ = exp_q.size() - ((rd_idx > flush_to) ? rd_idx : flush_to);
        if (!stop_v || p[2:0] > 3'd5 || (HAS_PAR && par_flip)) begin
            if (exp_err < 255) exp_err++;
        end else if (occ < DEPTH || pop_same) begin
            exp_q.push_back(p);
        end else if (exp_ovf < 255) begin
            exp_ovf++;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_serial = b;
        repeat (CPB) @(negedge clock);
    endtask

    // mode 0: plain, 1: check push latency, 2: ack on the stop-sample cycle
    task automatic send_frame(input logic [MSG_W-1:0] p, input logic stop_v,
                              input logic par_flip, input int mode);
        drive_bit(1'b0);
        for (int i = 0; i < MSG_W; i++) drive_bit(p[i]);
`ifdef COMM_RX_PARITY_EN
        drive_bit((^p) ^ par_flip);
`endif
        model_frame(p, stop_v, par_flip, mode == 2);
        rx_serial = stop_v;
        repeat (5) @(negedge clock);
        if (mode == 2) begin
            #1;
            stray_req++;
        end
        @(negedge clock);
        if (mode == 1) expect_eq("msg_before_stop", 32'(new_message_received), 32'd0);
        @(negedge clock);
        if (mode == 1) expect_eq("msg_after_stop", 32'(new_message_received), 32'd1);
        @(negedge clock);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        auto_ack = 1'b1;
        while ((rd_idx < exp_q.size() || new_message_received) && n < 400) begin
            @(negedge clock);
            n++;
        end
        expect_eq(name, 32'(rd_idx >= exp_q.size() && !new_message_received), 32'd1);
        auto_ack = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic check_counts(input string name);
        expect_eq({name, "_err"}, 32'(frame_err_count), 32'(exp_err));
        expect_eq({name, "_ovf"}, 32'(overflow_count), 32'(exp_ovf));
    endtask

    task automatic check_idle(input string name);
        expect_eq({name, "_msg"}, 32'(new_message_received), 32'd0);
        expect_eq({name, "_flags"}, 32'(flags), 32'd0);
        expect_eq({name, "_fields"},
                  32'({ball_y_rx, velocity_x_rx, velocity_y_rx, sign_y_rx}), 32'd0);
        expect_eq({name, "_busy"}, 32'(rx_busy), 32'd0);
    endtask

    initial begin
        logic [MSG_W-1:0] p;
        logic             st;
        reset     = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clock);
        check_idle("reset");
        check_counts("reset");
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Single BALL frame
        send_frame(mk(3'd0, 1'b1, 9'd300, 4'd5, 4'd3), 1'b1, 1'b0, 1);
        expect_eq("ball_y", 32'(ball_y_rx), 32'd300);
        expect_eq("ball_vx", 32'(velocity_x_rx), 32'd5);
        expect_eq("ball_vy", 32'(velocity_y_rx), 32'd3);
        expect_eq("ball_sign", 32'(sign_y_rx), 32'd1);
        expect_eq("ball_flag", 32'(flags), 32'd1);
        auto_ack = 1'b1;
        repeat (3) @(negedge clock);
        expect_eq("ball_acked", 32'(new_message_received), 32'd0);
        drain("drain_ball");

        // Five NEW_GAME frames without ack: one overflows
        for (int i = 0; i < 5; i++) send_frame(rnd(3'd5), 1'b1, 1'b0, 0);
        check_counts("overflow");
        expect_eq("overflow_msg", 32'(new_message_received), 32'd1);
        drain("drain_overflow");
        stray_req++;
        repeat (4) @(negedge clock);
        check_idle("stray_ack");
        check_counts("stray_ack");

        // Full FIFO with push and pop in the same cycle
        for (int i = 0; i < 4; i++) send_frame(rnd(3'($urandom_range(0, 5))), 1'b1, 1'b0, 0);
        send_frame(rnd(3'd2), 1'b1, 1'b0, 2);
        check_counts("full_pushpop");
        drain("drain_full_pushpop");

        // Empty FIFO with push and pop in the same cycle
        send_frame(rnd(3'd4), 1'b1, 1'b0, 2);
        expect_eq("empty_pushpop_msg", 32'(new_message_received), 32'd1);
        drain("drain_empty_pushpop");

        // Bad stop bit, then bad type, then a good MISS
        send_frame(rnd(3'd1), 1'b0, 1'b0, 0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(rnd(3'd7), 1'b1, 1'b0, 0);
        check_counts("bad_frames");
        expect_eq("bad_frames_msg", 32'(new_message_received), 32'd0);
        send_frame(rnd(3'd1), 1'b1, 1'b0, 0);
        expect_eq("miss_flag", 32'(miss_message_rx), 32'd1);
        drain("drain_miss");

        // Short low glitch
        rx_serial = 1'b0;
        repeat (3) @(negedge clock);
        rx_serial = 1'b1;
        @(negedge clock);
        expect_eq("glitch_busy", 32'(rx_busy), 32'd1);
        repeat (12) @(negedge clock);
        check_idle("glitch");
        check_counts("glitch");

        // Reset during data bit 10 with a message queued
        send_frame(rnd(3'd0), 1'b1, 1'b0, 0);
        p = rnd(3'd3);
        drive_bit(1'b0);
        for (int i = 0; i < 10; i++) drive_bit(p[i]);
        rx_serial = p[10];
        repeat (4) @(negedge clock);
        reset     = 1'b1;
        rx_serial = 1'b1;
        flush_to  = exp_q.size();
        exp_err   = 0;
        exp_ovf   = 0;
        @(negedge clock);
        reset = 1'b0;
        check_idle("mid_reset");
        check_counts("mid_reset");
        repeat (4) @(negedge clock);
        send_frame(p, 1'b1, 1'b0, 0);
        expect_eq("i_am_here_flag", 32'(I_am_here_rx), 32'd1);
        drain("drain_after_reset");

`ifdef COMM_RX_PARITY_EN
        p = rnd(3'd4);
        send_frame(p, 1'b1, 1'b0, 0);
        expect_eq("parity_ok_msg", 32'(I_lost_rx), 32'd1);
        drain("drain_parity");
        send_frame(p, 1'b1, 1'b1, 0);
        check_counts("parity_bad");
        expect_eq("parity_bad_msg", 32'(new_message_received), 32'd0);
`endif

        // Randomised traffic with intermittent acknowledgement
        for (int i = 0; i < 40; i++) begin
            auto_ack = $urandom_range(0, 3) != 0;
            st = $urandom_range(0, 7) != 0;
            send_frame(rnd(3'($urandom_range(0, 7))), st, 1'($urandom_range(0, 5) == 0), 0);
            if (!st) drive_bit(1'b1);
            repeat ($urandom_range(0, 2)) drive_bit(1'b1);
        end
        drain("drain_random");
        check_counts("final");
        check_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
